// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the hardwired control sequencer: instruction
// opcodes (IR[31:27]), the T-step state encoding, the instruction-class
// bit positions used by the class decoder, and the packed control word that
// carries every datapath strobe.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;

   // ALU code forced for effective-address and branch-target additions
   localparam logic [OP_W-1:0] ADD_OP = 5'b00011;

   // Opcodes
   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
   localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
   localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
   localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   // Sequencer steps: T0..T2 fetch, T3..T7 execute, HALT absorbing
   typedef enum logic [3:0] {
      T0   = 4'd0,
      T1   = 4'd1,
      T2   = 4'd2,
      T3   = 4'd3,
      T4   = 4'd4,
      T5   = 4'd5,
      T6   = 4'd6,
      T7   = 4'd7,
      HALT = 4'd8
   } state_t;

   // Bit positions inside the one-hot instruction class vector
   localparam int CLS_RTYPE  = 0;
   localparam int CLS_ITYPE  = 1;
   localparam int CLS_LD     = 2;
   localparam int CLS_LDI    = 3;
   localparam int CLS_ST     = 4;
   localparam int CLS_MULDIV = 5;
   localparam int CLS_UNARY  = 6;
   localparam int CLS_BR     = 7;
   localparam int CLS_JR     = 8;
   localparam int CLS_JAL    = 9;
   localparam int CLS_IN     = 10;
   localparam int CLS_OUT    = 11;
   localparam int CLS_MFHI   = 12;
   localparam int CLS_MFLO   = 13;
   localparam int CLS_NOP    = 14;
   localparam int CLS_HALT   = 15;
   localparam int NUM_CLS    = 16;

   // One field per datapath strobe
   typedef struct packed {
      logic gra;
      logic grb;
      logic grc;
      logic rin;
      logic rout;
      logic baOut;
      logic pcOut;
      logic pcIn;
      logic incPc;
      logic marIn;
      logic mdrIn;
      logic mdrRead;
      logic mdrOut;
      logic irIn;
      logic yIn;
      logic zIn;
      logic zloOut;
      logic zhiOut;
      logic hiIn;
      logic loIn;
      logic hiOut;
      logic loOut;
      logic cOut;
      logic inPortOut;
      logic outPortIn;
      logic ramWrite;
      logic conFfIn;
   } ctrl_word_t;

endpackage

// File: rtl/instr_class_decode.sv
// ----------------------------------------------------------------------------
// instr_class_decode
// Maps the 5-bit opcode onto a one-hot instruction class so the sequencer's
// step table only has to distinguish sixteen behaviours.
//   i_opcode  in  5   IR[31:27]
//   o_class   out 16  one-hot class, bit positions CLS_* from ctrl_pkg
// ----------------------------------------------------------------------------
module instr_class_decode
   import ctrl_pkg::*;
(
   input  logic [OP_W-1:0]    i_opcode,
   output logic [NUM_CLS-1:0] o_class
);

   // Pure lookup; unassigned opcodes 11100-11111 fall into the nop class
   always_comb begin
      o_class = '0;
      case (i_opcode) inside
         OP_LD:                 o_class[CLS_LD]     = 1'b1;
         OP_LDI:                o_class[CLS_LDI]    = 1'b1;
         OP_ST:                 o_class[CLS_ST]     = 1'b1;
         [OP_ADD:OP_SHL]:       o_class[CLS_RTYPE]  = 1'b1;
         OP_ADDI, OP_ANDI,
         OP_ORI:                o_class[CLS_ITYPE]  = 1'b1;
         OP_DIV, OP_MUL:        o_class[CLS_MULDIV] = 1'b1;
         OP_NEG, OP_NOT:        o_class[CLS_UNARY]  = 1'b1;
         OP_BR:                 o_class[CLS_BR]     = 1'b1;
         OP_JR:                 o_class[CLS_JR]     = 1'b1;
         OP_JAL:                o_class[CLS_JAL]    = 1'b1;
         OP_IN:                 o_class[CLS_IN]     = 1'b1;
         OP_OUT:                o_class[CLS_OUT]    = 1'b1;
         OP_MFHI:               o_class[CLS_MFHI]   = 1'b1;
         OP_MFLO:               o_class[CLS_MFLO]   = 1'b1;
         OP_HALT:               o_class[CLS_HALT]   = 1'b1;
         default:               o_class[CLS_NOP]    = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit for the CPU datapath. Steps T0..T7 per
// instruction (T0-T2 fetch, T3+ execute) and emits one control word per
// cycle, decoded from the current step, the latched IR opcode and CON.
//   clk        in   rising-edge clock
//   clr        in   asynchronous reset, active low
//   IR         in   instruction register (opcode = IR[31:27])
//   CON        in   branch-condition flip-flop, looked at in br T6 only
//   Stop       in   halt request, honoured at T0
//   Run        out  1 while sequencing, 0 in reset or HALT
//   Gra..CON_ff_in  out  datapath strobes
//   ALU_opcode out  ALU operation select (valid when Zin=1, else 0)
// ----------------------------------------------------------------------------
module control_sequencer
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic [DATA_W-1:0] IR,
   input  logic              CON,
   input  logic              Stop,
   output logic              Run,
   output logic              Gra,
   output logic              Grb,
   output logic              Grc,
   output logic              Rin,
   output logic              Rout,
   output logic              BAout,
   output logic              PCout,
   output logic              PCin,
   output logic              IncPC,
   output logic              MARin,
   output logic              MDRin,
   output logic              MDRread,
   output logic              MDRout,
   output logic              IRin,
   output logic              Yin,
   output logic              Zin,
   output logic              ZLOout,
   output logic              ZHIout,
   output logic              HIin,
   output logic              LOin,
   output logic              HIout,
   output logic              LOout,
   output logic              Cout,
   output logic              InPortout,
   output logic              OutPortin,
   output logic              RAM_write,
   output logic              CON_ff_in,
   output logic [OP_W-1:0]   ALU_opcode
);

   state_t             r_state;
   state_t             w_nextState;
   logic [OP_W-1:0]    w_opcode;
   logic [NUM_CLS-1:0] w_class;
   ctrl_word_t         w_ctrl;
   ctrl_word_t         w_gated;
   logic               w_aluAdd;
   logic [OP_W-1:0]    w_alu;
   logic               w_endT3;
   logic               w_endT4;
   logic               w_endT5;
   logic               w_endT6;
   logic               w_unusedIrBits;

   assign w_opcode       = IR[DATA_W-1:DATA_W-OP_W];
   assign w_unusedIrBits = ^IR[DATA_W-OP_W-1:0];

   instr_class_decode u_classDecode (
      .i_opcode (w_opcode),
      .o_class  (w_class)
   );

   // Which classes finish after each execute step
   assign w_endT3 = w_class[CLS_JR] | w_class[CLS_IN] | w_class[CLS_OUT] |
                    w_class[CLS_MFHI] | w_class[CLS_MFLO] | w_class[CLS_NOP];
   assign w_endT4 = w_class[CLS_UNARY] | w_class[CLS_JAL];
   assign w_endT5 = w_class[CLS_RTYPE] | w_class[CLS_ITYPE] | w_class[CLS_LDI];
   assign w_endT6 = w_class[CLS_MULDIV] | w_class[CLS_BR];

   // Single state register; reset parks the sequencer at T0 so it fetches
   // on the first cycle after clr is released
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= T0;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-step selection: fetch is linear, execute length depends on class,
   // HALT only leaves through reset
   always_comb begin
      w_nextState = T0;
      case (r_state)
         T0:      w_nextState = Stop ? HALT : T1;
         T1:      w_nextState = T2;
         T2:      w_nextState = T3;
         T3: begin
            if (w_class[CLS_HALT]) begin
               w_nextState = HALT;
            end else if (w_endT3) begin
               w_nextState = T0;
            end else begin
               w_nextState = T4;
            end
         end
         T4:      w_nextState = w_endT4 ? T0 : T5;
         T5:      w_nextState = w_endT5 ? T0 : T6;
         T6:      w_nextState = w_endT6 ? T0 : T7;
         T7:      w_nextState = T0;
         HALT:    w_nextState = HALT;
         default: w_nextState = T0;
      endcase
   end

   // Step table: control word for (step, class); every strobe starts at 0
   // and only the ones needed for the current micro-step are raised.
   // w_aluAdd marks steps that compute an address/target and must add
   // regardless of the instruction's own opcode.
   always_comb begin
      w_ctrl   = '0;
      w_aluAdd = 1'b0;
      case (r_state)
         T0: begin
            if (!Stop) begin
               w_ctrl.pcOut = 1'b1;
               w_ctrl.marIn = 1'b1;
               w_ctrl.incPc = 1'b1;
            end
         end
         T1: begin
            w_ctrl.mdrRead = 1'b1;
            w_ctrl.mdrIn   = 1'b1;
         end
         T2: begin
            w_ctrl.mdrOut = 1'b1;
            w_ctrl.irIn   = 1'b1;
         end
         T3: begin
            if (w_class[CLS_RTYPE] | w_class[CLS_ITYPE]) begin
               w_ctrl.grb  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.yIn  = 1'b1;
            end else if (w_class[CLS_LDI] | w_class[CLS_LD] | w_class[CLS_ST]) begin
               w_ctrl.grb   = 1'b1;
               w_ctrl.baOut = 1'b1;
               w_ctrl.yIn   = 1'b1;
            end else if (w_class[CLS_MULDIV]) begin
               w_ctrl.gra  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.yIn  = 1'b1;
            end else if (w_class[CLS_UNARY]) begin
               w_ctrl.grb  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.zIn  = 1'b1;
            end else if (w_class[CLS_BR]) begin
               w_ctrl.gra     = 1'b1;
               w_ctrl.rout    = 1'b1;
               w_ctrl.conFfIn = 1'b1;
            end else if (w_class[CLS_JR]) begin
               w_ctrl.gra  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.pcIn = 1'b1;
            end else if (w_class[CLS_JAL]) begin
               w_ctrl.pcOut = 1'b1;
               w_ctrl.grb   = 1'b1;
               w_ctrl.rin   = 1'b1;
            end else if (w_class[CLS_IN]) begin
               w_ctrl.inPortOut = 1'b1;
               w_ctrl.gra       = 1'b1;
               w_ctrl.rin       = 1'b1;
            end else if (w_class[CLS_OUT]) begin
               w_ctrl.gra       = 1'b1;
               w_ctrl.rout      = 1'b1;
               w_ctrl.outPortIn = 1'b1;
            end else if (w_class[CLS_MFHI]) begin
               w_ctrl.hiOut = 1'b1;
               w_ctrl.gra   = 1'b1;
               w_ctrl.rin   = 1'b1;
            end else if (w_class[CLS_MFLO]) begin
               w_ctrl.loOut = 1'b1;
               w_ctrl.gra   = 1'b1;
               w_ctrl.rin   = 1'b1;
            end
         end
         T4: begin
            if (w_class[CLS_RTYPE]) begin
               w_ctrl.grc  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.zIn  = 1'b1;
            end else if (w_class[CLS_ITYPE]) begin
               w_ctrl.cOut = 1'b1;
               w_ctrl.zIn  = 1'b1;
            end else if (w_class[CLS_LDI] | w_class[CLS_LD] | w_class[CLS_ST]) begin
               w_ctrl.cOut = 1'b1;
               w_ctrl.zIn  = 1'b1;
               w_aluAdd    = 1'b1;
            end else if (w_class[CLS_MULDIV]) begin
               w_ctrl.grb  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.zIn  = 1'b1;
            end else if (w_class[CLS_UNARY]) begin
               w_ctrl.zloOut = 1'b1;
               w_ctrl.gra    = 1'b1;
               w_ctrl.rin    = 1'b1;
            end else if (w_class[CLS_BR]) begin
               w_ctrl.pcOut = 1'b1;
               w_ctrl.yIn   = 1'b1;
            end else if (w_class[CLS_JAL]) begin
               w_ctrl.gra  = 1'b1;
               w_ctrl.rout = 1'b1;
               w_ctrl.pcIn = 1'b1;
            end
         end
         T5: begin
            if (w_class[CLS_RTYPE] | w_class[CLS_ITYPE] | w_class[CLS_LDI]) begin
               w_ctrl.zloOut = 1'b1;
               w_ctrl.gra    = 1'b1;
               w_ctrl.rin    = 1'b1;
            end else if (w_class[CLS_LD] | w_class[CLS_ST]) begin
               w_ctrl.zloOut = 1'b1;
               w_ctrl.marIn  = 1'b1;
            end else if (w_class[CLS_MULDIV]) begin
               w_ctrl.zloOut = 1'b1;
               w_ctrl.loIn   = 1'b1;
            end else if (w_class[CLS_BR]) begin
               w_ctrl.cOut = 1'b1;
               w_ctrl.zIn  = 1'b1;
               w_aluAdd    = 1'b1;
            end
         end
         T6: begin
            if (w_class[CLS_LD]) begin
               w_ctrl.mdrRead = 1'b1;
               w_ctrl.mdrIn   = 1'b1;
            end else if (w_class[CLS_ST]) begin
               w_ctrl.gra   = 1'b1;
               w_ctrl.rout  = 1'b1;
               w_ctrl.mdrIn = 1'b1;
            end else if (w_class[CLS_MULDIV]) begin
               w_ctrl.zhiOut = 1'b1;
               w_ctrl.hiIn   = 1'b1;
            end else if (w_class[CLS_BR] && CON) begin
               w_ctrl.zloOut = 1'b1;
               w_ctrl.pcIn   = 1'b1;
            end
         end
         T7: begin
            if (w_class[CLS_LD]) begin
               w_ctrl.mdrOut = 1'b1;
               w_ctrl.gra    = 1'b1;
               w_ctrl.rin    = 1'b1;
            end else if (w_class[CLS_ST]) begin
               w_ctrl.ramWrite = 1'b1;
            end
         end
         default: begin
            w_ctrl   = '0;
            w_aluAdd = 1'b0;
         end
      endcase
   end

   // ALU select only matters while Z is loading; address/target adds
   // override the instruction's own opcode
   always_comb begin
      w_alu = '0;
      if (w_ctrl.zIn) begin
         w_alu = w_aluAdd ? ADD_OP : w_opcode;
      end
   end

   // clr forces every output low immediately, independent of the clock
   assign w_gated    = clr ? w_ctrl : '0;
   assign ALU_opcode = clr ? w_alu : '0;
   assign Run        = clr && (r_state != HALT);

   assign Gra       = w_gated.gra;
   assign Grb       = w_gated.grb;
   assign Grc       = w_gated.grc;
   assign Rin       = w_gated.rin;
   assign Rout      = w_gated.rout;
   assign BAout     = w_gated.baOut;
   assign PCout     = w_gated.pcOut;
   assign PCin      = w_gated.pcIn;
   assign IncPC     = w_gated.incPc;
   assign MARin     = w_gated.marIn;
   assign MDRin     = w_gated.mdrIn;
   assign MDRread   = w_gated.mdrRead;
   assign MDRout    = w_gated.mdrOut;
   assign IRin      = w_gated.irIn;
   assign Yin       = w_gated.yIn;
   assign Zin       = w_gated.zIn;
   assign ZLOout    = w_gated.zloOut;
   assign ZHIout    = w_gated.zhiOut;
   assign HIin      = w_gated.hiIn;
   assign LOin      = w_gated.loIn;
   assign HIout     = w_gated.hiOut;
   assign LOout     = w_gated.loOut;
   assign Cout      = w_gated.cOut;
   assign InPortout = w_gated.inPortOut;
   assign OutPortin = w_gated.outPortIn;
   assign RAM_write = w_gated.ramWrite;
   assign CON_ff_in = w_gated.conFfIn;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer: walks reset, add, st, br (both CON
// values), mul, jal, neg, an unassigned opcode, halt and Stop, comparing the
// full strobe vector, Run and ALU_opcode against hand-derived words.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

   logic        clk;
   logic        clr;
   logic [31:0] IR;
   logic        CON;
   logic        Stop;
   logic        Run;
   logic        Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin;
   logic        MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLOout, ZHIout;
   logic        HIin, LOin, HIout, LOout, Cout, InPortout, OutPortin;
   logic        RAM_write, CON_ff_in;
   logic [4:0]  ALU_opcode;
   logic [26:0] obsStrobes;

   int errors = 0;
   int checks = 0;

   // Strobe bit positions in obsStrobes
   localparam logic [26:0] M_GRA   = 27'd1 << 0;
   localparam logic [26:0] M_GRB   = 27'd1 << 1;
   localparam logic [26:0] M_GRC   = 27'd1 << 2;
   localparam logic [26:0] M_RIN   = 27'd1 << 3;
   localparam logic [26:0] M_ROUT  = 27'd1 << 4;
   localparam logic [26:0] M_BAOUT = 27'd1 << 5;
   localparam logic [26:0] M_PCOUT = 27'd1 << 6;
   localparam logic [26:0] M_PCIN  = 27'd1 << 7;
   localparam logic [26:0] M_INCPC = 27'd1 << 8;
   localparam logic [26:0] M_MARIN = 27'd1 << 9;
   localparam logic [26:0] M_MDRIN = 27'd1 << 10;
   localparam logic [26:0] M_MDRRD = 27'd1 << 11;
   localparam logic [26:0] M_MDROUT= 27'd1 << 12;
   localparam logic [26:0] M_IRIN  = 27'd1 << 13;
   localparam logic [26:0] M_YIN   = 27'd1 << 14;
   localparam logic [26:0] M_ZIN   = 27'd1 << 15;
   localparam logic [26:0] M_ZLOOUT= 27'd1 << 16;
   localparam logic [26:0] M_ZHIOUT= 27'd1 << 17;
   localparam logic [26:0] M_HIIN  = 27'd1 << 18;
   localparam logic [26:0] M_LOIN  = 27'd1 << 19;
   localparam logic [26:0] M_HIOUT = 27'd1 << 20;
   localparam logic [26:0] M_LOOUT = 27'd1 << 21;
   localparam logic [26:0] M_COUT  = 27'd1 << 22;
   localparam logic [26:0] M_INPORT= 27'd1 << 23;
   localparam logic [26:0] M_OUTPRT= 27'd1 << 24;
   localparam logic [26:0] M_RAMWR = 27'd1 << 25;
   localparam logic [26:0] M_CONFF = 27'd1 << 26;
   localparam logic [26:0] NONE    = 27'd0;

   localparam logic [31:0] IR_ADD  = 32'h1891_8000;
   localparam logic [31:0] IR_ST   = 32'h1000_0000;
   localparam logic [31:0] IR_BR   = 32'h9800_0000;
   localparam logic [31:0] IR_MUL  = 32'h8000_0000;
   localparam logic [31:0] IR_JAL  = 32'hA800_0000;
   localparam logic [31:0] IR_NEG  = 32'h8800_0000;
   localparam logic [31:0] IR_X1F  = 32'hF800_0000;
   localparam logic [31:0] IR_HALT = 32'hD800_0000;

   control_sequencer dut (
      .clk        (clk),
      .clr        (clr),
      .IR         (IR),
      .CON        (CON),
      .Stop       (Stop),
      .Run        (Run),
      .Gra        (Gra),
      .Grb        (Grb),
      .Grc        (Grc),
      .Rin        (Rin),
      .Rout       (Rout),
      .BAout      (BAout),
      .PCout      (PCout),
      .PCin       (PCin),
      .IncPC      (IncPC),
      .MARin      (MARin),
      .MDRin      (MDRin),
      .MDRread    (MDRread),
      .MDRout     (MDRout),
      .IRin       (IRin),
      .Yin        (Yin),
      .Zin        (Zin),
      .ZLOout     (ZLOout),
      .ZHIout     (ZHIout),
      .HIin       (HIin),
      .LOin       (LOin),
      .HIout      (HIout),
      .LOout      (LOout),
      .Cout       (Cout),
      .InPortout  (InPortout),
      .OutPortin  (OutPortin),
      .RAM_write  (RAM_write),
      .CON_ff_in  (CON_ff_in),
      .ALU_opcode (ALU_opcode)
   );

   assign obsStrobes = {CON_ff_in, RAM_write, OutPortin, InPortout, Cout,
                        LOout, HIout, LOin, HIin, ZHIout, ZLOout, Zin, Yin,
                        IRin, MDRout, MDRread, MDRin, MARin, IncPC, PCin,
                        PCout, BAout, Rout, Rin, Grc, Grb, Gra};

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so a broken design can never hang the run
   initial begin
      #50000;
      $display("[TB] FAIL timeout: simulation did not finish, required finish before 50000");
      $fatal(1, "[TB] timeout");
   end

   // Drive the instruction-side inputs, then let combinational outputs settle
   task automatic applyStimulus(input logic [31:0] ir, input logic con, input logic stop);
      IR   = ir;
      CON  = con;
      Stop = stop;
      #1;
   endtask

   // Move one cycle on; sampling happens 1 ns after the rising edge
   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Compare Run, ALU_opcode and every strobe in one shot
   task automatic checkOutput(input string tag, input logic [26:0] expStrobes,
                              input logic [4:0] expAlu, input logic expRun);
      logic [32:0] observed;
      logic [32:0] expected;
      observed = {Run, ALU_opcode, obsStrobes};
      expected = {expRun, expAlu, expStrobes};
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed {Run,ALU,strobes}=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Fetch T0..T2, leaving the sequencer at T3
   task automatic doFetch(input string tag);
      checkOutput({tag, " T0"}, M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b1);
      waitCycle();
      checkOutput({tag, " T1"}, M_MDRRD | M_MDRIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput({tag, " T2"}, M_MDROUT | M_IRIN, 5'd0, 1'b1);
      waitCycle();
   endtask

   initial begin
      // Reset held from time zero
      clr = 1'b0;
      applyStimulus(IR_ADD, 1'b0, 1'b0);
      waitCycle();
      checkOutput("reset a", NONE, 5'd0, 1'b0);
      waitCycle();
      checkOutput("reset b", NONE, 5'd0, 1'b0);
      clr = 1'b1;
      #1;

      // add interrupted at T4 by a 3-cycle reset
      doFetch("add1");
      checkOutput("add1 T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("add1 T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1);
      clr = 1'b0;
      #1;
      checkOutput("midreset async", NONE, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         waitCycle();
         checkOutput("midreset hold", NONE, 5'd0, 1'b0);
      end
      clr = 1'b1;
      #1;

      // Full add: 6 cycles, then a fresh T0
      doFetch("add2");
      checkOutput("add2 T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("add2 T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1);
      waitCycle();
      checkOutput("add2 T5", M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      waitCycle();

      // st: 8 cycles
      applyStimulus(IR_ST, 1'b0, 1'b0);
      doFetch("st");
      checkOutput("st T3", M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("st T4", M_COUT | M_ZIN, 5'b00011, 1'b1);
      waitCycle();
      checkOutput("st T5", M_ZLOOUT | M_MARIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("st T6", M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("st T7", M_RAMWR, 5'd0, 1'b1);
      waitCycle();

      // br, condition false: no PC load at T6
      applyStimulus(IR_BR, 1'b0, 1'b0);
      doFetch("br0");
      checkOutput("br0 T3", M_GRA | M_ROUT | M_CONFF, 5'd0, 1'b1);
      waitCycle();
      checkOutput("br0 T4", M_PCOUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("br0 T5", M_COUT | M_ZIN, 5'b00011, 1'b1);
      waitCycle();
      checkOutput("br0 T6", NONE, 5'd0, 1'b1);
      waitCycle();

      // br, condition true: target loaded into PC at T6
      applyStimulus(IR_BR, 1'b1, 1'b0);
      doFetch("br1");
      checkOutput("br1 T3", M_GRA | M_ROUT | M_CONFF, 5'd0, 1'b1);
      waitCycle();
      checkOutput("br1 T4", M_PCOUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("br1 T5", M_COUT | M_ZIN, 5'b00011, 1'b1);
      waitCycle();
      checkOutput("br1 T6", M_ZLOOUT | M_PCIN, 5'd0, 1'b1);
      waitCycle();

      // mul: LOin at T5, HIin at T6, 7 cycles
      applyStimulus(IR_MUL, 1'b0, 1'b0);
      doFetch("mul");
      checkOutput("mul T3", M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("mul T4", M_GRB | M_ROUT | M_ZIN, 5'b10000, 1'b1);
      waitCycle();
      checkOutput("mul T5", M_ZLOOUT | M_LOIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("mul T6", M_ZHIOUT | M_HIIN, 5'd0, 1'b1);
      waitCycle();

      // jal
      applyStimulus(IR_JAL, 1'b0, 1'b0);
      doFetch("jal");
      checkOutput("jal T3", M_PCOUT | M_GRB | M_RIN, 5'd0, 1'b1);
      waitCycle();
      checkOutput("jal T4", M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b1);
      waitCycle();

      // neg
      applyStimulus(IR_NEG, 1'b0, 1'b0);
      doFetch("neg");
      checkOutput("neg T3", M_GRB | M_ROUT | M_ZIN, 5'b10001, 1'b1);
      waitCycle();
      checkOutput("neg T4", M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1);
      waitCycle();

      // Unassigned opcode 11111 behaves as nop
      applyStimulus(IR_X1F, 1'b0, 1'b0);
      doFetch("op1f");
      checkOutput("op1f T3", NONE, 5'd0, 1'b1);
      waitCycle();

      // halt instruction: absorbing HALT
      applyStimulus(IR_HALT, 1'b0, 1'b0);
      doFetch("halt");
      checkOutput("halt T3", NONE, 5'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         waitCycle();
         checkOutput("halt idle", NONE, 5'd0, 1'b0);
      end

      // Reset leaves HALT
      clr = 1'b0;
      waitCycle();
      checkOutput("halt reset", NONE, 5'd0, 1'b0);
      clr = 1'b1;
      #1;
      checkOutput("recover T0", M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b1);

      // Stop at T0: no fetch strobes, then HALT
      applyStimulus(IR_ADD, 1'b0, 1'b1);
      checkOutput("stop T0", NONE, 5'd0, 1'b1);
      waitCycle();
      applyStimulus(IR_ADD, 1'b0, 1'b0);
      checkOutput("stop halt a", NONE, 5'd0, 1'b0);
      waitCycle();
      checkOutput("stop halt b", NONE, 5'd0, 1'b0);

      // Recover and sequence again
      clr = 1'b0;
      waitCycle();
      clr = 1'b1;
      #1;
      doFetch("after stop");
      checkOutput("after stop T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
